// File: rtl/div_issue_pkg.sv
// rtl/div_issue_pkg.sv - shared state encodings and divider handshake constants
package div_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  localparam logic        RST_ENABLE           = 1'b1;
  localparam logic        DIV_START            = 1'b1;
  localparam logic        DIV_STOP             = 1'b0;
  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

endpackage

// File: rtl/div_issue.sv
// rtl/div_issue.sv - EX-stage issue/writeback control for the iterative divider
//   clk, rst              : clock, async active-high reset
//   div_req_i, div_signed_i, div_op1_i, div_op2_i : DIV/DIVU request from EX
//   flush_i               : kills the in-flight divide
//   div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o : to divider
//   div_result_i, div_ready_i : {remainder, quotient} and ready from divider
//   stallreq_o            : pipeline stall (combinational)
//   hilo_we_o, hi_o, lo_o : registered HI/LO write
module div_issue
  import div_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] div_op1_i,
  input  logic [31:0] div_op2_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  div_state_e r_state;

  logic w_ready;
  assign w_ready = (div_ready_i == DIV_RESULT_READY);

  // Annul is raised for any flush while the divider is busy; it is harmless
  // when the result is ready in the same cycle since that result is dropped.
  assign div_annul_o = (r_state == ST_WAIT) && flush_i;

  assign stallreq_o = ((r_state == ST_IDLE) && div_req_i && !flush_i) ||
                      ((r_state == ST_WAIT) && !w_ready && !flush_i)  ||
                      ((r_state == ST_DONE) && div_req_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state       <= ST_IDLE;
      div_start_o   <= DIV_STOP;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= ZERO_WORD;
      div_opdata2_o <= ZERO_WORD;
      hilo_we_o     <= 1'b0;
      hi_o          <= ZERO_WORD;
      lo_o          <= ZERO_WORD;
    end else begin
      hilo_we_o <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (div_req_i && !flush_i) begin
            div_signed_o  <= div_signed_i;
            div_opdata1_o <= div_op1_i;
            div_opdata2_o <= div_op2_i;
            div_start_o   <= DIV_START;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            // A ready result coincident with the flush still has to be
            // drained through DONE so the divider sees start drop first.
            div_start_o <= DIV_STOP;
            r_state     <= w_ready ? ST_DONE : ST_IDLE;
          end else if (w_ready) begin
            hi_o        <= div_result_i[63:32];
            lo_o        <= div_result_i[31:0];
            hilo_we_o   <= 1'b1;
            div_start_o <= DIV_STOP;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!w_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          div_start_o <= DIV_STOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// tb/tb_div_issue.sv - randomized self-checking bench for div_issue
module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] div_op1_i;
  logic [31:0] div_op2_i;
  logic        flush_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;
  int writes = 0;

  div_issue dut (
    .clk(clk), .rst(rst),
    .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .div_op1_i(div_op1_i), .div_op2_i(div_op2_i),
    .flush_i(flush_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stallreq_o(stallreq_o),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MIPS division: quotient truncates toward zero, remainder takes the
  // dividend's sign; a zero divisor yields all zeros from the divider.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: normal, 1: flush without ready at WAIT cycle flush_at, 2: flush with ready
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int mode, input int flush_at, input int hold,
                        input logic nv, input logic ns, input logic [31:0] na, input logic [31:0] nb);
    logic [63:0] res;
    res = ref_div(s, a, b);
    div_req_i = 1'b1; div_signed_i = s; div_op1_i = a; div_op2_i = b;
    flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'h0;
    #1;
    chk("stall_idle_req", stallreq_o, 1);
    chk("annul_idle", div_annul_o, 0);
    step();
    div_req_i = 1'b0;
    div_op1_i = ~a; div_op2_i = ~b; div_signed_i = ~s;
    chk("start_after_accept", div_start_o, 1);
    chk("signed_latched", div_signed_o, s);
    chk("op1_latched", div_opdata1_o, a);
    chk("op2_latched", div_opdata2_o, b);
    chk("we_after_accept", hilo_we_o, 0);
    for (int c = 1; c <= lat; c++) begin
      if (mode == 1 && c == flush_at) begin
        flush_i = 1'b1;
        #1;
        chk("annul_flush", div_annul_o, 1);
        chk("stall_flush", stallreq_o, 0);
        step();
        flush_i = 1'b0;
        chk("start_after_flush", div_start_o, 0);
        chk("we_after_flush", hilo_we_o, 0);
        chk("hi_hold_flush", hi_o, exp_hi);
        chk("lo_hold_flush", lo_o, exp_lo);
        return;
      end
      #1;
      chk("stall_wait", stallreq_o, 1);
      chk("annul_wait", div_annul_o, 0);
      chk("start_stable", div_start_o, 1);
      chk("op1_stable", div_opdata1_o, a);
      chk("op2_stable", div_opdata2_o, b);
      step();
    end
    div_ready_i = 1'b1;
    div_result_i = res;
    if (mode == 2) flush_i = 1'b1;
    #1;
    chk("stall_ready", stallreq_o, 0);
    step();
    flush_i = 1'b0;
    div_result_i = 64'hDEAD_BEEF_0BAD_F00D;
    if (mode != 2) begin
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      writes++;
      chk("we_pulse", hilo_we_o, 1);
    end else begin
      chk("we_flush_ready", hilo_we_o, 0);
    end
    chk("hi_wb", hi_o, exp_hi);
    chk("lo_wb", lo_o, exp_lo);
    chk("start_done", div_start_o, 0);
    if (nv) begin
      div_req_i = 1'b1; div_signed_i = ns; div_op1_i = na; div_op2_i = nb;
    end
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("stall_done", stallreq_o, nv);
      chk("annul_done", div_annul_o, 0);
      step();
      chk("we_done", hilo_we_o, 0);
      chk("start_held_low", div_start_o, 0);
    end
    div_ready_i = 1'b0;
    #1;
    chk("stall_done_last", stallreq_o, nv);
    step();
    chk("we_exit_done", hilo_we_o, 0);
    chk("start_exit_done", div_start_o, 0);
    chk("hi_hold", hi_o, exp_hi);
    chk("lo_hold", lo_o, exp_lo);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          lat, mode;

    rst = 1'b1; div_req_i = 1'b0; div_signed_i = 1'b0; div_op1_i = 32'h0;
    div_op2_i = 32'h0; flush_i = 1'b0; div_result_i = 64'h0; div_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", div_start_o, 0);
    chk("rst_signed", div_signed_o, 0);
    chk("rst_op1", div_opdata1_o, 0);
    chk("rst_op2", div_opdata2_o, 0);
    chk("rst_we", hilo_we_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_stall", stallreq_o, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    do_div(1'b0, 32'd100, 32'd7, 5, 0, 0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("divu_100_7_hi", hi_o, 32'd2);
    chk("divu_100_7_lo", lo_o, 32'd14);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 3, 0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
    do_div(1'b0, 32'd5, 32'd0, 2, 0, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("divu_5_0_hi", hi_o, 32'h0);
    chk("divu_5_0_lo", lo_o, 32'h0);
    do_div(1'b0, 32'd999, 32'd10, 15, 1, 10, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_div(1'b0, 32'd64, 32'd8, 4, 2, 0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("flush_ready_hi_kept", hi_o, 32'h0);

    // flush in IDLE blocks acceptance only
    div_req_i = 1'b1; div_op1_i = 32'd9; div_op2_i = 32'd3; flush_i = 1'b1;
    #1;
    chk("stall_idle_flush", stallreq_o, 0);
    chk("annul_idle_flush", div_annul_o, 0);
    step();
    chk("no_accept_flush", div_start_o, 0);
    div_req_i = 1'b0; flush_i = 1'b0;

    // back-to-back: second request waits through DONE
    writes = 0;
    do_div(1'b0, 32'd50, 32'd3, 3, 0, 0, 2, 1'b1, 1'b0, 32'd77, 32'd5);
    chk("b2b_first_lo", lo_o, 32'd16);
    do_div(1'b0, 32'd77, 32'd5, 2, 0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_second_hi", hi_o, 32'd2);
    chk("b2b_second_lo", lo_o, 32'd15);
    chk("b2b_write_count", writes, 2);

    // reset in the middle of WAIT
    div_req_i = 1'b1; div_signed_i = 1'b0; div_op1_i = 32'd33; div_op2_i = 32'd4;
    step();
    div_req_i = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_start", div_start_o, 0);
    chk("midrst_we", hilo_we_o, 0);
    chk("midrst_hi", hi_o, 0);
    chk("midrst_lo", lo_o, 0);
    chk("midrst_op1", div_opdata1_o, 0);
    exp_hi = 32'h0; exp_lo = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat  = $urandom_range(1, 12);
      mode = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 2)) : 0;
      do_div(s, a, b, lat, mode, $urandom_range(1, lat), $urandom_range(0, 3),
             1'b0, 1'b0, 32'h0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high (`RstEnable).
REQ-003 SHALL have port div_req_i  in  1  DIV/DIVU instruction valid in EX.
REQ-004 SHALL have port div_signed_i  in  1  1 = DIV, 0 = DIVU.
REQ-005 SHALL have ports div_op1_i, div_op2_i  in  32 each  dividend and divisor from EX.
REQ-006 SHALL have port flush_i  in  1  pipeline flush/exception, kills the in-flight divide.
REQ-007 SHALL have port div_start_o  out  1  start level to divider (`DivStart/`DivStop).
REQ-008 SHALL have port div_annul_o  out  1  annul to divider.
REQ-009 SHALL have ports div_signed_o  out  1, div_opdata1_o, div_opdata2_o  out  32 each  held operands.
REQ-010 SHALL have ports div_result_i  in  64 {remainder, quotient}, and div_ready_i  in  1 (`DivResultReady).
REQ-011 SHALL have port stallreq_o  out  1  pipeline stall request, combinational.
REQ-012 SHALL have ports hilo_we_o  out  1, hi_o  out  32, lo_o  out  32  HI/LO write, registered.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE; encoding defined in the shared defines.
REQ-014 IDLE: div_req_i=1 and flush_i=0 SHALL, at the edge, latch div_signed_i/op1/op2 into the div_*_o registers, set div_start_o=1 and enter WAIT.
REQ-015 WAIT: div_start_o and the operand outputs SHALL remain stable until WAIT is exited.
REQ-016 WAIT, div_ready_i=1, flush_i=0 SHALL, at the edge, set hi_o=div_result_i[63:32], lo_o=div_result_i[31:0] and hilo_we_o=1, set div_start_o=0 and enter DONE.
REQ-017 hilo_we_o SHALL be a one-cycle pulse; hi_o/lo_o SHALL hold their last written value otherwise.
REQ-018 DONE: with div_start_o=0, the block SHALL wait until div_ready_i=0, then enter IDLE; requests SHALL NOT be accepted in DONE.
REQ-019 stallreq_o SHALL equal (IDLE and div_req_i and not flush_i) or (WAIT and not div_ready_i and not flush_i) or (DONE and div_req_i).
REQ-020 WAIT, flush_i=1, div_ready_i=0: div_annul_o SHALL be 1 in that cycle (combinational); at the edge the block SHALL clear div_start_o and enter IDLE; hilo_we_o SHALL NOT assert.
REQ-021 WAIT, flush_i=1 and div_ready_i=1 in the same cycle: the flush SHALL win, with no HI/LO write, div_start_o cleared and DONE entered to drain ready.
REQ-022 div_annul_o SHALL be 0 outside WAIT; flush_i in IDLE or DONE SHALL have no effect beyond blocking acceptance.
REQ-023 A divisor of 0 SHALL be issued normally, and the 64'h0 result returned by the divider SHALL be written to HI/LO.
REQ-024 Issue latency SHALL be 1 cycle from accept to div_start_o=1, and writeback SHALL occur 1 cycle after div_ready_i is sampled high.

Reset
REQ-025 On rst=1 the block SHALL asynchronously set state=IDLE, div_start_o=0, div_signed_o=0, operands=0, hilo_we_o=0 and hi_o=lo_o=0.
REQ-026 Reset mid-WAIT SHALL abandon the divide with no HI/LO write, since the divider is reset by the same rst.

Structure
REQ-027 State encodings, `DivStart/`DivStop, `DivResultReady/`DivResultNotReady, `RstEnable and `ZeroWord SHALL come from the shared defines file.
REQ-028 The block SHALL be a single module with no sub-modules, instantiated beside the divider in the EX stage.

Verification
REQ-029 The bench SHALL cover: DIVU 100/7 -> stall until ready, then one hilo_we_o pulse with hi_o=2, lo_o=14, then IDLE after ready drops.
REQ-030 The bench SHALL cover: DIV -7/2 -> lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF.
REQ-031 The bench SHALL cover: DIVU 5/0 -> hi_o=lo_o=0, hilo_we_o pulses once.
REQ-032 The bench SHALL cover: flush_i for 1 cycle at cycle 10 of WAIT -> div_annul_o=1 in that cycle, no hilo_we_o, and IDLE next cycle.
REQ-033 The bench SHALL cover: flush_i coincident with div_ready_i -> no hilo_we_o, DONE entered, IDLE after ready falls.
REQ-034 The bench SHALL cover: back-to-back DIVU requests -> second one stalled through DONE and accepted only in IDLE, with both results written in order.
